// File: rtl/vga_pkg.sv
// Timing constants shared by the VGA generator and receiver, plus the
// receiver lock-state encoding.
package vga_pkg;

    localparam int VGA_WIDTH    = 10;
    localparam int VGA_ADDR_W   = 19;
    localparam int VGA_PIX_W    = 12;
    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_V_ACTIVE = 480;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ALIGN  = 2'd1,
        LOCKED = 2'd2
    } vga_state_e;

endpackage

// File: rtl/vga_timing_receiver_if.sv
// Video stream into the receiver and the frame-buffer write port out of it.
interface vga_timing_receiver_if #(
    parameter int PIX_W  = 12,
    parameter int ADDR_W = 19,
    parameter int WIDTH  = 10
);

    logic              hsync_in;
    logic              vsync_in;
    logic              de_in;
    logic [PIX_W-1:0]  pixel_in;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [PIX_W-1:0]  wr_data;
    logic [WIDTH-1:0]  xpos;
    logic [WIDTH-1:0]  ypos;

    modport master (
        output hsync_in, vsync_in, de_in, pixel_in,
        input  wr_en, wr_addr, wr_data, xpos, ypos
    );

    modport slave (
        input  hsync_in, vsync_in, de_in, pixel_in,
        output wr_en, wr_addr, wr_data, xpos, ypos
    );

endinterface

// File: rtl/vga_edge_detect.sv
// Two-flop sampler: sig_r is the registered input, rise/fall compare it
// against a second registered copy.
module vga_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_in,
    output logic sig_r,
    output logic rise,
    output logic fall
);

    logic sig_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_r <= 1'b0;
            sig_d <= 1'b0;
        end else begin
            sig_r <= sig_in;
            sig_d <= sig_r;
        end
    end

    assign rise = sig_r & ~sig_d;
    assign fall = ~sig_r & sig_d;

endmodule

// File: rtl/vga_timing_receiver.sv
// Recovers pixel coordinates from an hsync/vsync/de stream, tracks lock
// against the expected active geometry and emits frame-buffer writes.
module vga_timing_receiver
    import vga_pkg::*;
#(
    parameter int               WIDTH        = VGA_WIDTH,
    parameter logic [WIDTH-1:0] EXP_H_ACTIVE = WIDTH'(VGA_H_ACTIVE),
    parameter logic [WIDTH-1:0] EXP_V_ACTIVE = WIDTH'(VGA_V_ACTIVE),
    parameter int               PIX_W        = VGA_PIX_W,
    parameter int               ADDR_W       = VGA_ADDR_W
) (
    input  logic                  pixel_clk,
    input  logic                  rst_n,
    vga_timing_receiver_if.slave  vid,
    output logic                  frame_start,
    output logic [WIDTH-1:0]      h_active,
    output logic [WIDTH-1:0]      v_active,
    output logic                  locked,
    output logic                  err
);

    function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    vga_state_e        state, state_nxt;
    logic              hsync_r, vsync_r, de_r;
    logic              fs, le;
    logic              hs_rise, hs_fall, vs_rise, de_rise;
    logic              unused_edges;
    logic [PIX_W-1:0]  pixel_r;
    logic [WIDTH-1:0]  x_cnt, line_cnt, line_cnt_le;
    logic [ADDR_W-1:0] line_base;
    logic              line_bad, le_bad, de_vs_bad, de_hs_bad;
    logic              frame_bad, v_ok, viol, wr_ok;

    vga_edge_detect u_hs (.clk(pixel_clk), .rst_n(rst_n), .sig_in(vid.hsync_in),
                          .sig_r(hsync_r), .rise(hs_rise), .fall(hs_fall));
    vga_edge_detect u_vs (.clk(pixel_clk), .rst_n(rst_n), .sig_in(vid.vsync_in),
                          .sig_r(vsync_r), .rise(vs_rise), .fall(fs));
    vga_edge_detect u_de (.clk(pixel_clk), .rst_n(rst_n), .sig_in(vid.de_in),
                          .sig_r(de_r), .rise(de_rise), .fall(le));

    assign unused_edges = ^{hs_rise, hs_fall, vs_rise, de_rise};

    // A line ending in the same cycle as the frame start still counts
    // towards this frame before the counters clear.
    assign line_cnt_le = le ? sat_inc(line_cnt) : line_cnt;
    assign le_bad      = le && (x_cnt != EXP_H_ACTIVE);
    assign de_vs_bad   = de_r && !vsync_r;
    assign de_hs_bad   = de_r && !hsync_r;
    assign v_ok        = (line_cnt_le == EXP_V_ACTIVE);
    assign frame_bad   = line_bad || le_bad || de_vs_bad;
    assign wr_ok       = de_r && (state == LOCKED) &&
                         (x_cnt < EXP_H_ACTIVE) && (line_cnt < EXP_V_ACTIVE);
    assign locked      = (state == LOCKED);

    always_comb begin
        state_nxt = state;
        viol      = 1'b0;
        unique case (state)
            SEARCH: if (fs) state_nxt = ALIGN;
            ALIGN:  if (fs && v_ok && !frame_bad) state_nxt = LOCKED;
            LOCKED: begin
                viol = le_bad || de_vs_bad || de_hs_bad || (fs && !v_ok);
                if (viol) state_nxt = ALIGN;
            end
            default: state_nxt = SEARCH;
        endcase
    end

    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= SEARCH;
            pixel_r     <= '0;
            x_cnt       <= '0;
            line_cnt    <= '0;
            line_base   <= '0;
            line_bad    <= 1'b0;
            h_active    <= '0;
            v_active    <= '0;
            frame_start <= 1'b0;
            err         <= 1'b0;
            vid.wr_en   <= 1'b0;
            vid.wr_addr <= '0;
            vid.wr_data <= '0;
            vid.xpos    <= '0;
            vid.ypos    <= '0;
        end else begin
            state   <= state_nxt;
            pixel_r <= vid.pixel_in;
            x_cnt   <= de_r ? sat_inc(x_cnt) : '0;

            if (fs) begin
                line_cnt  <= '0;
                line_base <= '0;
                line_bad  <= 1'b0;
            end else begin
                line_cnt <= line_cnt_le;
                if (le)                   line_base <= line_base + ADDR_W'(EXP_H_ACTIVE);
                if (le_bad || de_vs_bad)  line_bad  <= 1'b1;
            end

            if (le) h_active <= x_cnt;
            if (fs) v_active <= line_cnt_le;
            frame_start <= fs;
            err         <= viol;

            // Write port zeroes its payload whenever no write is issued.
            vid.wr_en   <= wr_ok;
            vid.wr_addr <= wr_ok ? line_base + ADDR_W'(x_cnt) : '0;
            vid.wr_data <= wr_ok ? pixel_r : '0;
            vid.xpos    <= wr_ok ? x_cnt : '0;
            vid.ypos    <= wr_ok ? line_cnt : '0;
        end
    end

endmodule

// File: tb/tb_vga_timing_receiver.sv
// Directed bench for vga_timing_receiver on a scaled 8x6 active geometry.
module tb_vga_timing_receiver;

    localparam int H  = 8;
    localparam int V  = 6;
    localparam int PW = 12;
    localparam int AW = 19;
    localparam int W  = 10;

    logic          pixel_clk = 1'b0;
    logic          rst_n     = 1'b0;
    logic          frame_start, locked, err;
    logic [W-1:0]  h_active, v_active;

    vga_timing_receiver_if #(.PIX_W(PW), .ADDR_W(AW), .WIDTH(W)) vid ();

    vga_timing_receiver #(
        .WIDTH(W), .EXP_H_ACTIVE(10'd8), .EXP_V_ACTIVE(10'd6),
        .PIX_W(PW), .ADDR_W(AW)
    ) dut (
        .pixel_clk(pixel_clk), .rst_n(rst_n), .vid(vid),
        .frame_start(frame_start), .h_active(h_active), .v_active(v_active),
        .locked(locked), .err(err)
    );

    always #5 pixel_clk = ~pixel_clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    logic [PW-1:0] pix_d1 = '0, pix_d2 = '0;

    always @(posedge pixel_clk) begin
        cyc    <= cyc + 1;
        pix_d1 <= vid.pixel_in;
        pix_d2 <= pix_d1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Write monitor: in a clean locked frame the k-th write lands at address k.
    int fr_writes = 0, prev_writes = 0, first_addr = -1, last_addr = -1;
    int last_x = -1, last_y = -1;
    int err_cnt = 0, err_cyc = -1, err_fs_cnt = 0, fs_cnt = 0;

    always @(negedge pixel_clk) begin
        if (frame_start === 1'b1) begin
            fs_cnt++;
            prev_writes = fr_writes;
            fr_writes   = 0;
        end
        if (err === 1'b1) begin
            err_cnt++;
            err_cyc = cyc;
            if (frame_start === 1'b1) err_fs_cnt++;
        end
        if (vid.wr_en === 1'b1) begin
            chk("wr_addr", 32'(vid.wr_addr), fr_writes);
            chk("wr_data", 32'(vid.wr_data), 32'(pix_d2));
            chk("xpos", 32'(vid.xpos), fr_writes % H);
            chk("ypos", 32'(vid.ypos), fr_writes / H);
            if (fr_writes == 0) first_addr = int'(vid.wr_addr);
            last_addr = int'(vid.wr_addr);
            last_x    = int'(vid.xpos);
            last_y    = int'(vid.ypos);
            fr_writes++;
        end
    end

    int pix_seq    = 0;
    int fall_cyc   = 0;
    int short_fall = 0;

    task automatic tick(input logic hs, input logic vs, input logic de);
        vid.hsync_in = hs;
        vid.vsync_in = vs;
        vid.de_in    = de;
        if (de) begin
            vid.pixel_in = PW'(pix_seq * 37 + 5);
            pix_seq++;
        end else begin
            vid.pixel_in = 12'hA5C;
        end
        @(posedge pixel_clk);
        #1;
    endtask

    task automatic drive_line(input int de_len, input logic vs, input logic vs_tail);
        repeat (2) tick(1'b0, vs, 1'b0);
        repeat (2) tick(1'b1, vs, 1'b0);
        repeat (de_len) tick(1'b1, vs, 1'b1);
        fall_cyc = cyc + 1;
        repeat (2) tick(1'b1, vs_tail, 1'b0);
    endtask

    task automatic drive_frame(input int n_lines, input int short_row,
                               input int short_len, input bit coincide);
        repeat (2) drive_line(0, 1'b0, 1'b0);
        drive_line(0, 1'b1, 1'b1);
        for (int r = 0; r < n_lines; r++) begin
            drive_line((r == short_row) ? short_len : H, 1'b1,
                       (coincide && r == n_lines - 1) ? 1'b0 : 1'b1);
            if (r == short_row) short_fall = fall_cyc;
        end
        if (!coincide) drive_line(0, 1'b1, 1'b1);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " locked"}, 32'(locked), 0);
        chk({tag, " err"}, 32'(err), 0);
        chk({tag, " frame_start"}, 32'(frame_start), 0);
        chk({tag, " wr_en"}, 32'(vid.wr_en), 0);
        chk({tag, " wr_addr"}, 32'(vid.wr_addr), 0);
        chk({tag, " wr_data"}, 32'(vid.wr_data), 0);
        chk({tag, " xpos"}, 32'(vid.xpos), 0);
        chk({tag, " ypos"}, 32'(vid.ypos), 0);
        chk({tag, " h_active"}, 32'(h_active), 0);
        chk({tag, " v_active"}, 32'(v_active), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vid.hsync_in = 1'b1;
        vid.vsync_in = 1'b1;
        vid.de_in    = 1'b0;
        vid.pixel_in = '0;
        repeat (3) @(posedge pixel_clk);
        #1;
        chk_zero("reset");
        rst_n = 1'b1;
        repeat (4) tick(1'b1, 1'b1, 1'b0);

        // Two clean frames: first aligns, second locks
        drive_frame(V, -1, 0, 0);
        chk("A locked", 32'(locked), 0);
        chk("A h_active", 32'(h_active), H);
        chk("A fs_cnt", fs_cnt, 1);
        drive_frame(V, -1, 0, 0);
        chk("B locked", 32'(locked), 1);
        chk("B v_active", 32'(v_active), V);
        chk("B h_active", 32'(h_active), H);
        chk("B fs_cnt", fs_cnt, 2);
        chk("B writes", fr_writes, H * V);
        chk("B first_addr", first_addr, 0);
        chk("B last_addr", last_addr, H * V - 1);
        chk("B last_x", last_x, H - 1);
        chk("B last_y", last_y, V - 1);
        chk("B err_cnt", err_cnt, 0);

        drive_frame(V, -1, 0, 0);
        chk("C writes", fr_writes, H * V);
        chk("C locked", 32'(locked), 1);

        // Short line in row 2 while locked
        drive_frame(V, 2, H - 1, 0);
        chk("D err_cnt", err_cnt, 1);
        chk("D err_cycle", err_cyc, short_fall + 1);
        chk("D locked", 32'(locked), 0);
        chk("D writes", fr_writes, 2 * H + H - 1);
        chk("D h_active", 32'(h_active), H);
        drive_frame(V, -1, 0, 0);
        chk("E locked", 32'(locked), 0);
        chk("E writes", fr_writes, 0);
        drive_frame(V, -1, 0, 0);
        chk("F locked", 32'(locked), 1);
        chk("F writes", fr_writes, H * V);
        chk("F err_cnt", err_cnt, 1);

        // One extra active line: dropped, flagged at the next frame start
        drive_frame(V + 1, -1, 0, 0);
        chk("G writes", fr_writes, H * V);
        chk("G locked", 32'(locked), 1);
        drive_frame(V, -1, 0, 0);
        chk("H err_cnt", err_cnt, 2);
        chk("H err_at_fs", err_fs_cnt, 1);
        chk("H v_active", 32'(v_active), V + 1);
        chk("H locked", 32'(locked), 0);
        chk("H writes", fr_writes, 0);
        drive_frame(V, -1, 0, 0);
        chk("I locked", 32'(locked), 1);
        chk("I writes", fr_writes, H * V);

        // Asynchronous reset in the middle of row 3
        repeat (2) drive_line(0, 1'b0, 1'b0);
        drive_line(0, 1'b1, 1'b1);
        repeat (3) drive_line(H, 1'b1, 1'b1);
        repeat (2) tick(1'b0, 1'b1, 1'b0);
        repeat (2) tick(1'b1, 1'b1, 1'b0);
        repeat (4) tick(1'b1, 1'b1, 1'b1);
        chk("J wr_en", 32'(vid.wr_en), 1);
        chk("J xpos", 32'(vid.xpos), 2);
        chk("J ypos", 32'(vid.ypos), 3);
        #2 rst_n = 1'b0;
        #1 chk_zero("async_rst");
        repeat (2) tick(1'b1, 1'b1, 1'b0);
        rst_n = 1'b1;
        repeat (2) tick(1'b1, 1'b1, 1'b0);
        drive_frame(V, -1, 0, 0);
        chk("K locked", 32'(locked), 0);
        chk("K writes", fr_writes, 0);
        drive_frame(V, -1, 0, 0);
        chk("L locked", 32'(locked), 1);
        chk("L writes", fr_writes, H * V);

        // Last de fall coincides with vsync fall
        drive_frame(V, -1, 0, 1);
        drive_frame(V, -1, 0, 0);
        chk("M writes", prev_writes, H * V);
        chk("M v_active", 32'(v_active), V);
        chk("M h_active", 32'(h_active), H);
        chk("M err_cnt", err_cnt, 2);
        chk("N locked", 32'(locked), 1);
        chk("N writes", fr_writes, H * V);
        chk("N first_addr", first_addr, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vga_timing_receiver.md
Name: vga_timing_receiver

Overview:
Sink-side counterpart of the VGA timing generator. Samples an incoming hsync/vsync/data-enable/pixel stream and recovers pixel coordinates. Checks the stream against the expected active geometry and maintains a lock state. Emits frame-buffer write strobes so a captured frame can feed the face-detection image memory.

Parameters:
WIDTH, 10, width of coordinate and measurement counters
EXP_H_ACTIVE, 10'd640, expected data-enable cycles per active line
EXP_V_ACTIVE, 10'd480, expected active lines per frame
PIX_W, 12, pixel data width (RGB444)
ADDR_W, 19, frame-buffer address width

Ports:
pixel_clk  in  1  pixel clock; all logic on rising edge
rst_n  in  1  asynchronous active-low reset
hsync_in  in  1  horizontal sync, low during pulse
vsync_in  in  1  vertical sync, low during pulse
de_in  in  1  data enable (active-video indicator)
pixel_in  in  PIX_W  pixel data, valid when de_in=1
wr_en  out  1  frame-buffer write strobe
wr_addr  out  ADDR_W  write address, ypos*EXP_H_ACTIVE+xpos
wr_data  out  PIX_W  pixel to write
xpos  out  WIDTH  column of pixel on wr_data
ypos  out  WIDTH  row of pixel on wr_data
frame_start  out  1  one-cycle pulse at each vsync falling edge
h_active  out  WIDTH  de length of last completed line
v_active  out  WIDTH  active-line count of last completed frame
locked  out  1  high while in LOCKED
err  out  1  one-cycle pulse on geometry violation in LOCKED

Behaviour:
- Interface: one clock, pixel_clk. Reset rst_n is asynchronous, active-low.
- Reset: all outputs 0; FSM enters SEARCH; all counters and input registers cleared. Reset mid-frame aborts the frame immediately; no write is issued until the next full frame qualifies.
- Input stage: every input is registered once (_r). Edge detection compares _r against a second registered copy.
  - Frame start (FS) = vsync_r falling edge.
  - Line end (LE) = de_r falling edge.
- Counters:
  - x_cnt counts de_r cycles within a line; cleared when de_r=0.
  - line_cnt increments on each LE; cleared on FS.
  - Both saturate at all-ones and never wrap.
- Measurements:
  - On LE, h_active <= final x_cnt.
  - On FS, v_active <= line_cnt.
  - line_bad is a sticky flag: set on LE when x_cnt != EXP_H_ACTIVE, or when de_r=1 while vsync_r=0; cleared on FS.
- FSM:
  - SEARCH -> ALIGN on first FS.
  - ALIGN -> LOCKED on FS when line_cnt==EXP_V_ACTIVE and !line_bad; otherwise stay in ALIGN.
  - LOCKED -> ALIGN with err pulse on any LE with x_cnt != EXP_H_ACTIVE, on de while vsync low, or on FS with line_cnt != EXP_V_ACTIVE.
  - err is asserted in the cycle after the violating event.
- Write path:
  - wr_en = de_r && state==LOCKED && x_cnt<EXP_H_ACTIVE && line_cnt<EXP_V_ACTIVE.
  - Outputs are registered, so wr_en/wr_data/xpos/ypos appear 2 cycles after de_in/pixel_in at the port.
  - On unlock, writes stop from the cycle after the violation is detected. Out-of-bounds pixels are dropped.
- Address generation: no multiplier.
  - line_base += EXP_H_ACTIVE on each LE; cleared on FS.
  - wr_addr = line_base + x_cnt.
  - When wr_en=0, xpos/ypos/wr_addr/wr_data hold 0.
- frame_start pulses in the cycle after FS is detected, in every state.
- Simultaneous FS and LE in the same cycle:
  - The LE measurement is taken first: h_active updated, line_cnt+1 used for the v_active/lock check.
  - Then line_cnt, line_base and line_bad clear.
- hsync: used only for consistency. In LOCKED, de_r=1 while hsync_r=0 is also a violation.

Decomposition:
- Package vga_pkg holds shared timing constants (640x480 active, WIDTH, ADDR_W) for both generator and receiver, plus the state enum SEARCH/ALIGN/LOCKED.
- One natural sub-module: vga_edge_detect, a two-flop sampler with rise/fall pulse outputs, instantiated per sync/de input.
- FSM, counters and address generator stay in the top module.

Test Plan:
1. Reset, then drive two clean 640x480 frames from the team timing generator -> locked=1 after the 2nd frame_start; v_active=480, h_active=640.
2. Third frame while locked -> exactly 307200 wr_en pulses; first wr_addr=0 (xpos=0, ypos=0); last wr_addr=307199 (xpos=639, ypos=479); wr_data equals pixel_in delayed 2 cycles.
3. Locked, then shorten one line's de to 639 cycles -> err pulse 1 cycle after that de falls; locked=0; no further wr_en; relock after the next two clean frame boundaries.
4. Frame with 481 active lines -> 481st line not written; at FS err=1, v_active=481, state ALIGN.
5. Assert rst_n=0 mid-line while locked -> all outputs 0 asynchronously; after release, locked stays 0 until two clean frames.
6. Force vsync and de falling edges into the same cycle -> h_active and v_active both update correctly; the next frame starts at wr_addr 0.
